// File: rtl/fifo_entry_serializer.sv
// Serializes one wide fifo_queue entry into narrow valid/ready beats, LSB beat first,
// acking the queue once the last beat is taken. FIFO_SERIALIZER_TRAILING_ZERO_SKIP_EN drops
// trailing all-zero beats.
module fifo_entry_serializer #(
    parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int unsigned BEAT_WIDTH_IN_BITS         = 8,
    parameter int unsigned NUM_BEATS                  = SINGLE_ENTRY_WIDTH_IN_BITS /
                                                        BEAT_WIDTH_IN_BITS,
    parameter int unsigned BEAT_CNT_WIDTH_IN_BITS     = $clog2(NUM_BEATS)
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                  request_valid_in,
    output logic                                  issue_ack_out,
    output logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out,
    output logic                                  beat_valid_out,
    output logic                                  beat_last_out,
    input  logic                                  beat_ready_in,
    output logic                                  busy_out
);

    localparam logic [BEAT_CNT_WIDTH_IN_BITS-1:0] FullLastIdx =
        BEAT_CNT_WIDTH_IN_BITS'(NUM_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StAck} state_e;

    state_e                                state_q, state_d;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] shift_q, shift_d, shift_next;
    logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [BEAT_WIDTH_IN_BITS-1:0]         beat_q, beat_d;
    logic                                  valid_q, valid_d;
    logic                                  last_q, last_d;
    logic                                  ack_q, ack_d;
    logic                                  busy_q, busy_d;
    logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     cap_last_idx;
    logic [BEAT_CNT_WIDTH_IN_BITS-1:0]     last_idx;

`ifdef FIFO_SERIALIZER_TRAILING_ZERO_SKIP_EN
    logic [BEAT_CNT_WIDTH_IN_BITS-1:0] last_idx_q, last_idx_d;

    // Highest non-zero beat wins; an all-zero entry still sends beat 0.
    always_comb begin
        cap_last_idx = '0;
        for (int unsigned i = 0; i < NUM_BEATS; i++) begin
            if (|request_in[i*BEAT_WIDTH_IN_BITS +: BEAT_WIDTH_IN_BITS]) begin
                cap_last_idx = BEAT_CNT_WIDTH_IN_BITS'(i);
            end
        end
    end

    assign last_idx_d = (state_q == StIdle && request_valid_in) ? cap_last_idx : last_idx_q;
    assign last_idx   = last_idx_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            last_idx_q <= '0;
        end else begin
            last_idx_q <= last_idx_d;
        end
    end
`else
    assign cap_last_idx = FullLastIdx;
    assign last_idx     = FullLastIdx;
`endif

    assign shift_next = shift_q >> BEAT_WIDTH_IN_BITS;
    assign cnt_inc    = cnt_q + BEAT_CNT_WIDTH_IN_BITS'(1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        last_d  = last_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (request_valid_in) begin
                    state_d = StSend;
                    shift_d = request_in;
                    cnt_d   = '0;
                    beat_d  = request_in[BEAT_WIDTH_IN_BITS-1:0];
                    valid_d = 1'b1;
                    last_d  = (cap_last_idx == '0);
                end
            end
            StSend: begin
                if (beat_ready_in) begin
                    if (cnt_q == last_idx) begin
                        state_d = StAck;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ack_d   = 1'b1;
                    end else begin
                        shift_d = shift_next;
                        cnt_d   = cnt_inc;
                        beat_d  = shift_next[BEAT_WIDTH_IN_BITS-1:0];
                        last_d  = (cnt_inc == last_idx);
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign issue_ack_out  = ack_q;
    assign beat_out       = beat_q;
    assign beat_valid_out = valid_q;
    assign beat_last_out  = last_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_fifo_entry_serializer.sv
// Directed bench for fifo_entry_serializer: per-cycle vector table plus hand-written
// sequences for queue back-to-back, mid-entry reset and idle stability.
module tb_fifo_entry_serializer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [63:0] request_in;
    logic        request_valid_in;
    logic        issue_ack_out;
    logic [7:0]  beat_out;
    logic        beat_valid_out;
    logic        beat_last_out;
    logic        beat_ready_in;
    logic        busy_out;

    int n_pass  = 0;
    int n_total = 0;

    fifo_entry_serializer dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .request_in      (request_in),
        .request_valid_in(request_valid_in),
        .issue_ack_out   (issue_ack_out),
        .beat_out        (beat_out),
        .beat_valid_out  (beat_valid_out),
        .beat_last_out   (beat_last_out),
        .beat_ready_in   (beat_ready_in),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       req_valid;
        logic       ready;
        logic [7:0] beat;
        logic       chk_beat;
        logic       valid;
        logic       last;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add(input logic rv, input logic rdy, input logic [7:0] b, input logic cb,
                       input logic v, input logic l, input logic a, input logic bz);
        vec_t r;
        r.req_valid = rv; r.ready = rdy; r.beat = b; r.chk_beat = cb;
        r.valid = v; r.last = l; r.ack = a; r.busy = bz;
        vecs.push_back(r);
    endtask

    // Expects the DUT idle at a negedge; sends e with ready high, checks n beats then the ack.
    task automatic run_entry(input logic [63:0] e, input int n);
        request_in       = e;
        request_valid_in = 1'b1;
        beat_ready_in    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            check("entry beat_valid", beat_valid_out, 1);
            check("entry beat", beat_out, e[i*8 +: 8]);
            check("entry beat_last", beat_last_out, (i == n - 1) ? 1 : 0);
            check("entry no early ack", issue_ack_out, 0);
        end
        @(negedge clk_in);
        check("entry ack", issue_ack_out, 1);
        check("entry valid after last", beat_valid_out, 0);
        request_valid_in = 1'b0;
        @(negedge clk_in);
        check("entry ack one cycle", issue_ack_out, 0);
        check("entry idle busy", busy_out, 0);
    endtask

    initial begin
        logic [63:0] entry;
        logic [63:0] q[3];
        logic [7:0]  got[$];
        int          head;
        int          acks;
        logic        bubble;

        entry            = 64'h0807060504030201;
        reset_in         = 1'b0;
        request_in       = '0;
        request_valid_in = 1'b0;
        beat_ready_in    = 1'b0;
        #1;
        check("reset beat", beat_out, 0);
        check("reset valid", beat_valid_out, 0);
        check("reset last", beat_last_out, 0);
        check("reset ack", issue_ack_out, 0);
        check("reset busy", busy_out, 0);
        @(negedge clk_in);
        reset_in = 1'b1;
        request_in = entry;

        // Full entry, ready high; queue bubble after the ack.
        add(1, 1, 8'h01, 1, 1, 0, 0, 1);
        for (int k = 2; k <= 8; k++) add(1, 1, 8'(k), 1, 1, k == 8, 0, 1);
        add(1, 1, 8'h00, 0, 0, 0, 1, 1);
        add(1, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);
        // Same entry with three stalled cycles on beat 03.
        add(1, 1, 8'h01, 1, 1, 0, 0, 1);
        add(1, 1, 8'h02, 1, 1, 0, 0, 1);
        add(1, 1, 8'h03, 1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) add(1, 0, 8'h03, 1, 1, 0, 0, 1);
        for (int k = 4; k <= 8; k++) add(1, 1, 8'(k), 1, 1, k == 8, 0, 1);
        add(1, 1, 8'h00, 0, 0, 0, 1, 1);
        add(1, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            request_valid_in = vecs[i].req_valid;
            beat_ready_in    = vecs[i].ready;
            @(negedge clk_in);
            if (vecs[i].chk_beat) check($sformatf("vec%0d beat", i), beat_out, vecs[i].beat);
            check($sformatf("vec%0d valid", i), beat_valid_out, vecs[i].valid);
            check($sformatf("vec%0d last", i), beat_last_out, vecs[i].last);
            check($sformatf("vec%0d ack", i), issue_ack_out, vecs[i].ack);
            check($sformatf("vec%0d busy", i), busy_out, vecs[i].busy);
        end

        // Back-to-back from a modelled 3-entry queue with intermittent ready.
        q[0] = {8{8'h11}}; q[1] = {8{8'h22}}; q[2] = {8{8'h33}};
        head = 0; acks = 0; bubble = 1'b0;
        request_in = q[0]; request_valid_in = 1'b1; beat_ready_in = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_in);
            if (issue_ack_out) begin
                acks++;
                head++;
                bubble = 1'b1;
            end else begin
                bubble = 1'b0;
            end
            request_in       = q[(head < 3) ? head : 0];
            request_valid_in = (head < 3) && !bubble;
            beat_ready_in    = (cyc % 3) != 1;
            if (beat_valid_out && beat_ready_in) got.push_back(beat_out);
            if (head == 3 && !busy_out) break;
        end
        request_valid_in = 1'b0;
        beat_ready_in    = 1'b1;
        check("b2b beat count", got.size(), 24);
        check("b2b ack count", acks, 3);
        check("b2b queue drained", head, 3);
        for (int i = 0; i < 24 && i < got.size(); i++) begin
            check($sformatf("b2b beat%0d", i), got[i], q[i/8][7:0]);
        end
        @(negedge clk_in);

        // Reset while beat 05 is shown: outputs clear at once, entry replayed from beat 01.
        acks = 0;
        request_in = entry; request_valid_in = 1'b1; beat_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (issue_ack_out) acks++;
        end
        check("pre-reset beat05", beat_out, 8'h05);
        #2 reset_in = 1'b0;
        #1;
        check("async reset beat", beat_out, 0);
        check("async reset valid", beat_valid_out, 0);
        check("async reset last", beat_last_out, 0);
        check("async reset ack", issue_ack_out, 0);
        check("async reset busy", busy_out, 0);
        check("no ack before reset", acks, 0);
        @(negedge clk_in);
        reset_in = 1'b1;
        run_entry(entry, 8);

`ifdef FIFO_SERIALIZER_TRAILING_ZERO_SKIP_EN
        run_entry(64'h0000000000000A05, 2);
        run_entry(64'h0, 1);
`else
        run_entry(64'h0000000000000A05, 8);
`endif

        // Idle stability.
        request_valid_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check("idle valid", beat_valid_out, 0);
            check("idle ack", issue_ack_out, 0);
            check("idle busy", busy_out, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
